// File: rtl/elevator_pkg.sv
// Shared floor encoding, controller state type and floor decode helper
// for the elevator dispatcher.
package elevator_pkg;

    localparam int FLOOR_W    = 2;
    localparam int NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        DOOR_OPEN,
        FAULT
    } state_t;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

endpackage

// File: rtl/next_floor_sel.sv
// Combinational SCAN target selector: keeps the travel direction while calls
// remain ahead of the car, otherwise reverses to the nearest call behind it.
module next_floor_sel
    import elevator_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending_i,
    input  logic [FLOOR_W-1:0]    cur_floor_i,
    input  logic                  dir_up_i,
    output logic                  tgt_valid_o,
    output logic [FLOOR_W-1:0]    tgt_floor_o,
    output logic                  dir_next_o
);

    logic               up_found;
    logic               dn_found;
    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;

    always_comb begin
        up_found    = 1'b0;
        dn_found    = 1'b0;
        up_floor    = '0;
        dn_floor    = '0;
        tgt_valid_o = 1'b0;
        tgt_floor_o = '0;
        dir_next_o  = dir_up_i;

        // Descending scan leaves the nearest call above; ascending the nearest below.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending_i[i] && (i > int'(cur_floor_i))) begin
                up_found = 1'b1;
                up_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending_i[i] && (i < int'(cur_floor_i))) begin
                dn_found = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end

        if (dir_up_i) begin
            if (up_found) begin
                tgt_valid_o = 1'b1;
                tgt_floor_o = up_floor;
                dir_next_o  = 1'b1;
            end else if (dn_found) begin
                tgt_valid_o = 1'b1;
                tgt_floor_o = dn_floor;
                dir_next_o  = 1'b0;
            end
        end else begin
            if (dn_found) begin
                tgt_valid_o = 1'b1;
                tgt_floor_o = dn_floor;
                dir_next_o  = 1'b0;
            end else if (up_found) begin
                tgt_valid_o = 1'b1;
                tgt_floor_o = up_floor;
                dir_next_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_dispatcher.sv
// Latches call buttons, issues SCAN-ordered floor requests to the elevator,
// times the door dwell and flags a car that stops reporting progress.
module elevator_dispatcher
    import elevator_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  emergency,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  fault
);

    localparam int DT_W = $clog2(DOOR_CYCLES + 1);
    localparam int MT_W = $clog2(MOVE_TIMEOUT);
    localparam logic [DT_W-1:0] DOOR_LOAD = DT_W'(DOOR_CYCLES - 1);
    localparam logic [MT_W-1:0] MOVE_LAST = MT_W'(MOVE_TIMEOUT - 1);

    state_t                state_q;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    req_floor_q;
    logic                  req_valid_q;
    logic                  door_open_q;
    logic                  dir_up_q;
    logic                  fault_q;
    logic [DT_W-1:0]       door_tmr_q;
    logic [MT_W-1:0]       move_tmr_q;
    logic [FLOOR_W-1:0]    cur_floor_q;

    logic                  arrive;
    logic                  enter_door;
    logic [NUM_FLOORS-1:0] clr;
    logic [NUM_FLOORS-1:0] btn_mask;
    logic                  tgt_valid;
    logic [FLOOR_W-1:0]    tgt_floor;
    logic                  dir_next;

    next_floor_sel u_sel (
        .pending_i   (pending_q),
        .cur_floor_i (cur_floor),
        .dir_up_i    (dir_up_q),
        .tgt_valid_o (tgt_valid),
        .tgt_floor_o (tgt_floor),
        .dir_next_o  (dir_next)
    );

    // The stop floor is cleared on door entry; presses at the open floor only re-open it.
    always_comb begin
        arrive     = (state_q == MOVING) && (cur_floor == req_floor_q);
        enter_door = arrive || ((state_q == IDLE) && pending_q[cur_floor]);
        clr        = enter_door ? floor_onehot(cur_floor) : '0;
        btn_mask   = (state_q == DOOR_OPEN) ? floor_onehot(cur_floor) : '0;
        pending_d  = (pending_q | (call_btn & ~btn_mask)) & ~clr;
    end

    always_ff @(posedge clk or posedge emergency) begin
        if (emergency) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
            door_open_q <= 1'b0;
            dir_up_q    <= 1'b1;
            fault_q     <= 1'b0;
            door_tmr_q  <= '0;
            move_tmr_q  <= '0;
            cur_floor_q <= '0;
        end else begin
            pending_q   <= pending_d;
            cur_floor_q <= cur_floor;
            case (state_q)
                IDLE: begin
                    if (pending_q[cur_floor]) begin
                        state_q     <= DOOR_OPEN;
                        door_open_q <= 1'b1;
                        door_tmr_q  <= DOOR_LOAD;
                    end else if (tgt_valid) begin
                        state_q     <= MOVING;
                        req_floor_q <= tgt_floor;
                        req_valid_q <= 1'b1;
                        dir_up_q    <= dir_next;
                        move_tmr_q  <= '0;
                    end
                end
                MOVING: begin
                    if (arrive) begin
                        state_q     <= DOOR_OPEN;
                        req_valid_q <= 1'b0;
                        door_open_q <= 1'b1;
                        door_tmr_q  <= DOOR_LOAD;
                    end else if (move_tmr_q == MOVE_LAST) begin
                        state_q     <= FAULT;
                        req_valid_q <= 1'b0;
                        fault_q     <= 1'b1;
                    end else if (cur_floor != cur_floor_q) begin
                        move_tmr_q  <= '0;
                    end else begin
                        move_tmr_q  <= move_tmr_q + 1'b1;
                    end
                end
                DOOR_OPEN: begin
                    if (call_btn[cur_floor]) begin
                        door_tmr_q  <= DOOR_LOAD;
                    end else if (door_tmr_q == '0) begin
                        state_q     <= IDLE;
                        door_open_q <= 1'b0;
                    end else begin
                        door_tmr_q  <= door_tmr_q - 1'b1;
                    end
                end
                FAULT: begin
                    req_valid_q <= 1'b0;
                    door_open_q <= 1'b0;
                    fault_q     <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_floor = req_floor_q;
    assign req_valid = req_valid_q;
    assign door_open = door_open_q;
    assign dir_up    = dir_up_q;
    assign pending   = pending_q;
    assign fault     = fault_q;

endmodule
